boundarycell: RTL and testbench

- Diagonal (boundary) processing element of the QRD-RLS systolic array.
- It is the producer of the rotation pair that the internal cells consume.
- Each accepted input sample xin annihilates against the stored diagonal element r, using a Givens rotation: r_new = sqrt(r^2 + xin^2), c = r/r_new, s = xin/r_new.
- It emits c and s to the right-hand internal cell, with a one-cycle ready_out pulse, and keeps r_new for the next sample.

---
 rtl/boundarycell.sv | 168 ++++++++++++++++
 tb/tb_boundarycell.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/boundarycell.sv
// Boundary (diagonal) cell of the QRD-RLS systolic array.
// A Givens rotation annihilates each accepted sample xin against the stored
// diagonal element r. The cell then hands the rotation pair (c, s) to the
// internal cell on its right. r_new comes from a bit-serial restoring square
// root. c and s come from two restoring dividers that run side by side.
module boundarycell #(
    parameter int DATA_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ready_in,
    input  logic [DATA_LENGTH-1:0] xin,
    output logic [DATA_LENGTH-1:0] c_out,
    output logic [DATA_LENGTH-1:0] s_out,
    output logic                   ready_out,
    output logic                   busy,
    output logic [DATA_LENGTH-1:0] r_out
);

    localparam int N  = DATA_LENGTH;
    localparam int CW = $clog2(N + 2);
    localparam int SW = N + 3;
    localparam int DW = N + 1;

    localparam logic [N-1:0]  MAXV = {N{1'b1}};
    localparam logic [CW-1:0] LAST = CW'(N);
    localparam logic [CW-1:0] FIN  = CW'(N + 1);

    typedef enum logic [1:0] {IDLE, SQRT, DIV} state_t;
    typedef logic [SW-1:0] sq_rem_t;
    typedef logic [DW-1:0] dv_rem_t;

    state_t state, state_nx;

    logic [CW-1:0]  cnt;
    logic [N-1:0]   x_reg;
    logic [N-1:0]   r_reg;
    logic [2*N+1:0] sum_sh;
    logic [SW-1:0]  sq_rem;
    logic [N:0]     root;
    logic [DW-1:0]  dc_rem, ds_rem;
    logic [N:0]     dc_sh, ds_sh;
    logic [N:0]     qc, qs;

    logic [2*N+1:0] r_ext, x_ext, sum_init;
    logic [SW+1:0]  sq_cand, sq_trial;
    logic           sq_take;
    logic [N-1:0]   divisor;
    logic [DW:0]    dc_cand, ds_cand, div_ext;
    logic           dc_take, ds_take;

    assign busy  = (state != IDLE);
    assign r_out = r_reg;

    // One square-root step and one step of each divider, plus r^2 + x^2 for a newly accepted sample.
    // The root is held at all-ones once it no longer fits in DATA_LENGTH bits.
    always_comb begin
        r_ext    = {{(N+2){1'b0}}, r_reg};
        x_ext    = {{(N+2){1'b0}}, xin};
        sum_init = r_ext * r_ext + x_ext * x_ext;

        sq_cand  = {sq_rem, sum_sh[2*N+1:2*N]};
        sq_trial = {3'b000, root, 2'b01};
        sq_take  = (sq_cand >= sq_trial);

        divisor  = root[N] ? MAXV : root[N-1:0];
        div_ext  = {2'b00, divisor};
        dc_cand  = {dc_rem, dc_sh[N]};
        ds_cand  = {ds_rem, ds_sh[N]};
        dc_take  = (dc_cand >= div_ext);
        ds_take  = (ds_cand >= div_ext);
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic: accept only when idle, then run the root phase, then the divide phase
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (ready_in)     state_nx = SQRT;
            SQRT: if (cnt == LAST)  state_nx = DIV;
            DIV:  if (cnt == FIN)   state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // Datapath: latch the sample, iterate the root and divider bits, then publish results for one ready cycle.
    // Each divider starts at quotient bit N with remainder = dividend >> (N+1), i.e. operand >> 1.
    // The dividend is operand * 2^N. Because r_new >= both operands, this partial remainder is already below
    // the divisor, so N+1 quotient bits are enough.
    // When r_new is zero, both dividers are ignored and c = 1.0, s = 0 are published instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            x_reg     <= '0;
            r_reg     <= '0;
            sum_sh    <= '0;
            sq_rem    <= '0;
            root      <= '0;
            dc_rem    <= '0;
            ds_rem    <= '0;
            dc_sh     <= '0;
            ds_sh     <= '0;
            qc        <= '0;
            qs        <= '0;
            c_out     <= '0;
            s_out     <= '0;
            ready_out <= 1'b0;
        end else begin
            ready_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (ready_in) begin
                        x_reg  <= xin;
                        sum_sh <= sum_init;
                        sq_rem <= '0;
                        root   <= '0;
                        cnt    <= '0;
                    end
                end
                SQRT: begin
                    sum_sh <= {sum_sh[2*N-1:0], 2'b00};
                    sq_rem <= sq_take ? sq_rem_t'(sq_cand - sq_trial) : sq_rem_t'(sq_cand);
                    root   <= {root[N-1:0], sq_take};
                    if (cnt == LAST) begin
                        cnt    <= '0;
                        dc_rem <= {2'b00, r_reg[N-1:1]};
                        ds_rem <= {2'b00, x_reg[N-1:1]};
                        dc_sh  <= {r_reg[0], {N{1'b0}}};
                        ds_sh  <= {x_reg[0], {N{1'b0}}};
                        qc     <= '0;
                        qs     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DIV: begin
                    if (cnt == FIN) begin
                        if (divisor == '0) begin
                            c_out <= MAXV;
                            s_out <= '0;
                        end else begin
                            c_out <= qc[N] ? MAXV : qc[N-1:0];
                            s_out <= qs[N] ? MAXV : qs[N-1:0];
                        end
                        r_reg     <= divisor;
                        ready_out <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        dc_rem <= dc_take ? dv_rem_t'(dc_cand - div_ext) : dv_rem_t'(dc_cand);
                        ds_rem <= ds_take ? dv_rem_t'(ds_cand - div_ext) : dv_rem_t'(ds_cand);
                        dc_sh  <= {dc_sh[N-1:0], 1'b0};
                        ds_sh  <= {ds_sh[N-1:0], 1'b0};
                        qc     <= {qc[N-1:0], dc_take};
                        qs     <= {qs[N-1:0], ds_take};
                        cnt    <= cnt + 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_boundarycell.sv
// Bench for the boundary cell.
// A reference rotation model computes expected results from integer sqrt and division.
module tb_boundarycell;

    localparam int N    = 8;
    localparam int MAXV = (1 << N) - 1;
    localparam int LAT  = 2 * N + 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ready_in = 1'b0;
    logic [N-1:0] xin = '0;
    logic [N-1:0] c_out, s_out, r_out;
    logic         ready_out, busy;

    int checks = 0;
    int errors = 0;
    int model_r = 0;
    int exp_c = 0;
    int exp_s = 0;

    boundarycell #(.DATA_LENGTH(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .ready_in  (ready_in),
        .xin       (xin),
        .c_out     (c_out),
        .s_out     (s_out),
        .ready_out (ready_out),
        .busy      (busy),
        .r_out     (r_out)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int isqrt(input int v);
        int q = 0;
        while ((q + 1) * (q + 1) <= v) q++;
        return q;
    endfunction

    function automatic int sat(input int v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    // Reference rotation from the mathematical definition
    task automatic model_rotate(input int x);
        int rn;
        rn = sat(isqrt(model_r * model_r + x * x));
        if (rn == 0) begin
            exp_c = MAXV;
            exp_s = 0;
        end else begin
            exp_c = sat((model_r << N) / rn);
            exp_s = sat((x << N) / rn);
        end
        model_r = rn;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ready_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_output("rst_c", c_out, 0);
        check_output("rst_s", s_out, 0);
        check_output("rst_r", r_out, 0);
        check_output("rst_ready", ready_out, 0);
        check_output("rst_busy", busy, 0);
        model_r = 0;
        exp_c = 0;
        exp_s = 0;
    endtask

    // Offer one sample, optionally poke ready_in (xin=7) at edges inj_a/inj_b or reset at edge rst_at
    task automatic apply_stimulus(input int x, input int inj_a, input int inj_b, input int rst_at);
        int edges;
        bit seen;
        @(negedge clk);
        ready_in = 1'b1;
        xin = N'(x);
        @(posedge clk);
        #1;
        ready_in = 1'b0;
        xin = N'($urandom_range(0, MAXV));
        check_output("busy_accept", busy, 1);
        check_output("ready_pulse_end", ready_out, 0);
        check_output("hold_c", c_out, exp_c);
        check_output("hold_s", s_out, exp_s);
        check_output("hold_r", r_out, model_r);
        if (rst_at == 0) model_rotate(x);
        edges = 0;
        seen = 1'b0;
        while (!seen && edges < LAT + 10) begin
            if (edges + 1 == inj_a || edges + 1 == inj_b) begin
                ready_in = 1'b1;
                xin = 8'd7;
            end
            if (rst_at != 0 && edges + 1 == rst_at) rst = 1'b1;
            @(posedge clk);
            #1;
            edges++;
            ready_in = 1'b0;
            rst = 1'b0;
            if (ready_out) begin
                seen = 1'b1;
            end else if (rst_at != 0 && edges == rst_at) begin
                check_output("abort_c", c_out, 0);
                check_output("abort_s", s_out, 0);
                check_output("abort_r", r_out, 0);
                check_output("abort_busy", busy, 0);
                model_r = 0;
                exp_c = 0;
                exp_s = 0;
            end else if (rst_at == 0) begin
                check_output("busy_during", busy, 1);
            end
        end
        if (rst_at == 0) begin
            check_output("ready_seen", seen, 1);
            check_output("latency", edges, LAT);
            check_output("busy_at_ready", busy, 0);
            check_output("c_out", c_out, exp_c);
            check_output("s_out", s_out, exp_s);
            check_output("r_out", r_out, model_r);
        end else begin
            check_output("no_ready_after_rst", seen, 0);
        end
    endtask

    initial begin
        int x;
        int inj;
        $display("[TB] start");
        do_reset();

        apply_stimulus(3, 0, 0, 0);
        check_output("dir_r3", r_out, 3);
        check_output("dir_c0", c_out, 0);
        check_output("dir_s255", s_out, 255);
        apply_stimulus(4, 0, 0, 0);
        check_output("dir_r5", r_out, 5);
        check_output("dir_c153", c_out, 153);
        check_output("dir_s204", s_out, 204);
        apply_stimulus(0, 0, 0, 0);
        check_output("dir_x0_c", c_out, 255);
        check_output("dir_x0_s", s_out, 0);

        do_reset();
        apply_stimulus(0, 0, 0, 0);
        check_output("zero_c", c_out, 255);
        check_output("zero_r", r_out, 0);

        do_reset();
        apply_stimulus(255, 0, 0, 0);
        apply_stimulus(255, 0, 0, 0);
        check_output("sat_r", r_out, 255);
        check_output("sat_c", c_out, 255);
        check_output("sat_s", s_out, 255);

        do_reset();
        apply_stimulus(3, 3, 10, 0);
        @(posedge clk);
        #1;
        check_output("single_pulse", ready_out, 0);
        check_output("ignored_r", r_out, 3);

        apply_stimulus(9, 0, 0, 10);
        apply_stimulus(3, 0, 0, 0);
        check_output("after_abort_r", r_out, 3);
        check_output("after_abort_s", s_out, 255);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) do_reset();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            case ($urandom_range(0, 3))
                0:       x = 0;
                1:       x = $urandom_range(0, 15);
                default: x = $urandom_range(0, MAXV);
            endcase
            inj = ($urandom_range(0, 3) == 0) ? $urandom_range(1, LAT - 1) : 0;
            apply_stimulus(x, inj, 0, 0);
        end

        @(posedge clk);
        #1;
        check_output("final_pulse_end", ready_out, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
